// File: rtl/rst_seq_gen.sv
// Purpose : reset sequencer; merges POR, debounced pad reset and software reset into per-domain
//           active-low resets that are stretched, then released one domain at a time in index order.
// Latency : rst_no[k] rises on edge STRETCH_CYCLES + k*STAGE_GAP after the source clears; sw re-entry
//           takes 1 edge; pad re-entry takes SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges.
// Backpr. : none; requests are sampled every cycle and never queued.
// Ports   : clk_i, rst_ni (POR, async active-low), ext_rst_ni (pad, async), sw_rst_req_i (1-cycle pulse)
//           -> rst_no[NUM_DOMAINS] (registered), seq_done_o, busy_o, rst_cause_o (00 POR, 01 pad, 10 sw).
module rst_seq_gen #(
    parameter int NUM_DOMAINS     = 3,
    parameter int STRETCH_CYCLES  = 16,
    parameter int STAGE_GAP       = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   ext_rst_ni,
    input  logic                   sw_rst_req_i,
    output logic [NUM_DOMAINS-1:0] rst_no,
    output logic                   seq_done_o,
    output logic                   busy_o,
    output logic [1:0]             rst_cause_o
);

    localparam int MAX_SG  = (STRETCH_CYCLES > STAGE_GAP) ? STRETCH_CYCLES : STAGE_GAP;
    localparam int MAX_CNT = (MAX_SG > DEBOUNCE_CYCLES) ? MAX_SG : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] DEB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    localparam logic [1:0] CAUSE_EXT = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'b00,
        ST_RELEASE = 2'b01,
        ST_RUN     = 2'b10
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ext_synced;
    logic [CNT_W-1:0]       deb_cnt;
    logic                   ext_req;
    logic [NUM_DOMAINS-1:0] rst_next;
    logic                   reenter;

    // Pad reset synchronizer; idles high so a POR does not look like a pad press.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ext_rst_ni};
        end
    end

    assign ext_synced = sync_q[SYNC_STAGES-1];

    // Debounce: ext_req rises on the DEBOUNCE_CYCLES-th consecutive synced-low sample
    // and drops on the first synced-high sample. The count saturates.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            deb_cnt <= '0;
            ext_req <= 1'b0;
        end else if (ext_synced) begin
            deb_cnt <= '0;
            ext_req <= 1'b0;
        end else begin
            if (deb_cnt >= DEB_LAST) begin
                ext_req <= 1'b1;
            end
            if (deb_cnt != CNT_MAX) begin
                deb_cnt <= deb_cnt + CNT_ONE;
            end
        end
    end

    // rst_no is a thermometer code, so shifting in a 1 releases the next index in order.
    assign rst_next = NUM_DOMAINS'({rst_no, 1'b1});
    assign reenter  = ext_req || sw_rst_req_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_ASSERT;
            cnt         <= '0;
            rst_no      <= '0;
            seq_done_o  <= 1'b0;
            busy_o      <= 1'b1;
            rst_cause_o <= 2'b00;
        end else begin
            case (state)
                ST_ASSERT: begin
                    // A held pad reset keeps the stretch from starting; sw requests are ignored here.
                    if (ext_req) begin
                        cnt <= '0;
                    end else if (cnt == STRETCH_LAST) begin
                        cnt    <= '0;
                        rst_no <= NUM_DOMAINS'(1);
                        if (NUM_DOMAINS == 1) begin
                            state      <= ST_RUN;
                            seq_done_o <= 1'b1;
                            busy_o     <= 1'b0;
                        end else begin
                            state <= ST_RELEASE;
                        end
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_RELEASE, ST_RUN: begin
                    if (reenter) begin
                        // Pad wins over software when both land on the same edge.
                        state       <= ST_ASSERT;
                        cnt         <= '0;
                        rst_no      <= '0;
                        seq_done_o  <= 1'b0;
                        busy_o      <= 1'b1;
                        rst_cause_o <= ext_req ? CAUSE_EXT : CAUSE_SW;
                    end else if (state == ST_RELEASE) begin
                        if (cnt == GAP_LAST) begin
                            cnt    <= '0;
                            rst_no <= rst_next;
                            if (&rst_next) begin
                                state      <= ST_RUN;
                                seq_done_o <= 1'b1;
                                busy_o     <= 1'b0;
                            end
                        end else if (cnt != CNT_MAX) begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state      <= ST_ASSERT;
                    cnt        <= '0;
                    rst_no     <= '0;
                    seq_done_o <= 1'b0;
                    busy_o     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq_gen.sv
// Purpose : self-checking bench for rst_seq_gen at default parameters (3 domains, 16/8/2/4).
// Latency : expected outputs are queued per absolute clock edge and compared 1 ns after that edge.
// Backpr. : n/a.
`timescale 1ns/1ps
module tb_rst_seq_gen;

    logic       clk_i        = 1'b0;
    logic       rst_ni       = 1'b0;
    logic       ext_rst_ni   = 1'b1;
    logic       sw_rst_req_i = 1'b0;
    logic [2:0] rst_no;
    logic       seq_done_o;
    logic       busy_o;
    logic [1:0] rst_cause_o;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         cyc;
        logic [2:0] rst;
        logic       done;
        logic [1:0] cause;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    rst_seq_gen #(
        .NUM_DOMAINS    (3),
        .STRETCH_CYCLES (16),
        .STAGE_GAP      (8),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .ext_rst_ni  (ext_rst_ni),
        .sw_rst_req_i(sw_rst_req_i),
        .rst_no      (rst_no),
        .seq_done_o  (seq_done_o),
        .busy_o      (busy_o),
        .rst_cause_o (rst_cause_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Expected release ramp when edge b+1 is the first counting edge.
    function automatic void push_seq(input int b, input logic [1:0] c, input string nm);
        sb.push_back('{b + 15, 3'b000, 1'b0, c, {nm, "_pre"}});
        sb.push_back('{b + 16, 3'b001, 1'b0, c, {nm, "_d0"}});
        sb.push_back('{b + 23, 3'b001, 1'b0, c, {nm, "_gap1"}});
        sb.push_back('{b + 24, 3'b011, 1'b0, c, {nm, "_d1"}});
        sb.push_back('{b + 31, 3'b011, 1'b0, c, {nm, "_gap2"}});
        sb.push_back('{b + 32, 3'b111, 1'b1, c, {nm, "_done"}});
        sb.push_back('{b + 36, 3'b111, 1'b1, c, {nm, "_run"}});
    endfunction

    task automatic test_reset();
        int base;
        rst_ni = 1'b0; ext_rst_ni = 1'b1; sw_rst_req_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if ({rst_no, seq_done_o, busy_o, rst_cause_o} !== 7'b000_0_1_00) begin
            failures++;
            $display("FAIL reset_state: rst_no=%b done=%b busy=%b cause=%b, want 000 0 1 00",
                     rst_no, seq_done_o, busy_o, rst_cause_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        base = cyc;
        push_seq(base, 2'b00, "por");
        while (sb.size() > 0) begin
            @(posedge clk_i); #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.cyc != cyc || rst_no !== e.rst || seq_done_o !== e.done ||
                    busy_o !== ~e.done || rst_cause_o !== e.cause) begin
                    failures++;
                    $display("FAIL %s edge=%0d: rst_no=%b done=%b busy=%b cause=%b, want rst_no=%b done=%b cause=%b",
                             e.name, e.cyc, rst_no, seq_done_o, busy_o, rst_cause_o, e.rst, e.done, e.cause);
                end
            end
        end
    endtask

    task automatic test_ext_glitch();
        int base;
        @(negedge clk_i);
        ext_rst_ni = 1'b0;
        base = cyc;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        ext_rst_ni = 1'b1;
        for (int i = 4; i <= 14; i++) sb.push_back('{base + i, 3'b111, 1'b1, 2'b00, "ext_glitch"});
        while (sb.size() > 0) begin
            @(posedge clk_i); #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.cyc != cyc || rst_no !== e.rst || seq_done_o !== e.done ||
                    busy_o !== ~e.done || rst_cause_o !== e.cause) begin
                    failures++;
                    $display("FAIL %s edge=%0d: rst_no=%b done=%b busy=%b cause=%b, want rst_no=%b done=%b cause=%b",
                             e.name, e.cyc, rst_no, seq_done_o, busy_o, rst_cause_o, e.rst, e.done, e.cause);
                end
            end
        end
    endtask

    task automatic test_ext_hold();
        int base;
        @(negedge clk_i);
        ext_rst_ni = 1'b0;
        base = cyc;
        // 2 sync edges + 4 debounce edges raise ext_req at base+6; FSM reacts at base+7.
        sb.push_back('{base + 1,  3'b111, 1'b1, 2'b00, "ext_hold_sync"});
        sb.push_back('{base + 6,  3'b111, 1'b1, 2'b00, "ext_hold_deb"});
        sb.push_back('{base + 7,  3'b000, 1'b0, 2'b01, "ext_hold_assert"});
        sb.push_back('{base + 14, 3'b000, 1'b0, 2'b01, "ext_hold_mid"});
        sb.push_back('{base + 20, 3'b000, 1'b0, 2'b01, "ext_hold_end"});
        while (sb.size() > 0) begin
            @(posedge clk_i); #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.cyc != cyc || rst_no !== e.rst || seq_done_o !== e.done ||
                    busy_o !== ~e.done || rst_cause_o !== e.cause) begin
                    failures++;
                    $display("FAIL %s edge=%0d: rst_no=%b done=%b busy=%b cause=%b, want rst_no=%b done=%b cause=%b",
                             e.name, e.cyc, rst_no, seq_done_o, busy_o, rst_cause_o, e.rst, e.done, e.cause);
                end
            end
        end
        @(negedge clk_i);
        ext_rst_ni = 1'b1;
        // Synced high at base+22, ext_req drops at base+23, counting starts on base+24.
        sb.push_back('{base + 30, 3'b000, 1'b0, 2'b01, "ext_rel_wait"});
        push_seq(base + 23, 2'b01, "ext_rel");
        while (sb.size() > 0) begin
            @(posedge clk_i); #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.cyc != cyc || rst_no !== e.rst || seq_done_o !== e.done ||
                    busy_o !== ~e.done || rst_cause_o !== e.cause) begin
                    failures++;
                    $display("FAIL %s edge=%0d: rst_no=%b done=%b busy=%b cause=%b, want rst_no=%b done=%b cause=%b",
                             e.name, e.cyc, rst_no, seq_done_o, busy_o, rst_cause_o, e.rst, e.done, e.cause);
                end
            end
        end
    endtask

    task automatic test_sw_run();
        int t;
        @(negedge clk_i);
        sw_rst_req_i = 1'b1;
        t = cyc + 1;
        @(posedge clk_i); #1;
        sw_rst_req_i = 1'b0;
        checks++;
        if ({rst_no, seq_done_o, busy_o, rst_cause_o} !== 7'b000_0_1_10) begin
            failures++;
            $display("FAIL sw_run_assert: rst_no=%b done=%b busy=%b cause=%b, want 000 0 1 10",
                     rst_no, seq_done_o, busy_o, rst_cause_o);
        end
        push_seq(t, 2'b10, "sw_run");
        while (sb.size() > 0) begin
            @(posedge clk_i); #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.cyc != cyc || rst_no !== e.rst || seq_done_o !== e.done ||
                    busy_o !== ~e.done || rst_cause_o !== e.cause) begin
                    failures++;
                    $display("FAIL %s edge=%0d: rst_no=%b done=%b busy=%b cause=%b, want rst_no=%b done=%b cause=%b",
                             e.name, e.cyc, rst_no, seq_done_o, busy_o, rst_cause_o, e.rst, e.done, e.cause);
                end
            end
        end
    endtask

    task automatic test_sw_release();
        int t;
        int t2;
        @(negedge clk_i);
        sw_rst_req_i = 1'b1;
        t = cyc + 1;
        @(posedge clk_i); #1;
        sw_rst_req_i = 1'b0;
        sb.push_back('{t + 16, 3'b001, 1'b0, 2'b10, "sw_rel_d0"});
        sb.push_back('{t + 19, 3'b001, 1'b0, 2'b10, "sw_rel_mid"});
        while (sb.size() > 0) begin
            @(posedge clk_i); #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.cyc != cyc || rst_no !== e.rst || seq_done_o !== e.done ||
                    busy_o !== ~e.done || rst_cause_o !== e.cause) begin
                    failures++;
                    $display("FAIL %s edge=%0d: rst_no=%b done=%b busy=%b cause=%b, want rst_no=%b done=%b cause=%b",
                             e.name, e.cyc, rst_no, seq_done_o, busy_o, rst_cause_o, e.rst, e.done, e.cause);
                end
            end
        end
        // Second pulse lands mid-gap; the ramp must restart from a cleared counter.
        @(negedge clk_i);
        sw_rst_req_i = 1'b1;
        t2 = cyc + 1;
        @(posedge clk_i); #1;
        sw_rst_req_i = 1'b0;
        checks++;
        if ({rst_no, seq_done_o, busy_o, rst_cause_o} !== 7'b000_0_1_10) begin
            failures++;
            $display("FAIL sw_rel_assert: rst_no=%b done=%b busy=%b cause=%b, want 000 0 1 10",
                     rst_no, seq_done_o, busy_o, rst_cause_o);
        end
        push_seq(t2, 2'b10, "sw_rel");
        while (sb.size() > 0) begin
            @(posedge clk_i); #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.cyc != cyc || rst_no !== e.rst || seq_done_o !== e.done ||
                    busy_o !== ~e.done || rst_cause_o !== e.cause) begin
                    failures++;
                    $display("FAIL %s edge=%0d: rst_no=%b done=%b busy=%b cause=%b, want rst_no=%b done=%b cause=%b",
                             e.name, e.cyc, rst_no, seq_done_o, busy_o, rst_cause_o, e.rst, e.done, e.cause);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        int base;
        @(negedge clk_i);
        ext_rst_ni = 1'b0;
        base = cyc;
        repeat (6) @(negedge clk_i);
        sw_rst_req_i = 1'b1;
        @(posedge clk_i); #1;
        sw_rst_req_i = 1'b0;
        ext_rst_ni = 1'b1;
        checks++;
        if (cyc != base + 7 || {rst_no, seq_done_o, busy_o, rst_cause_o} !== 7'b000_0_1_01) begin
            failures++;
            $display("FAIL simul_cause edge=%0d: rst_no=%b done=%b busy=%b cause=%b, want 000 0 1 01 at edge %0d",
                     cyc, rst_no, seq_done_o, busy_o, rst_cause_o, base + 7);
        end
        push_seq(base + 10, 2'b01, "simul");
        while (sb.size() > 0) begin
            @(posedge clk_i); #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.cyc != cyc || rst_no !== e.rst || seq_done_o !== e.done ||
                    busy_o !== ~e.done || rst_cause_o !== e.cause) begin
                    failures++;
                    $display("FAIL %s edge=%0d: rst_no=%b done=%b busy=%b cause=%b, want rst_no=%b done=%b cause=%b",
                             e.name, e.cyc, rst_no, seq_done_o, busy_o, rst_cause_o, e.rst, e.done, e.cause);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int base;
        @(negedge clk_i);
        sw_rst_req_i = 1'b1;
        @(posedge clk_i); #1;
        sw_rst_req_i = 1'b0;
        repeat (20) @(posedge clk_i);
        #1;
        checks++;
        if ({rst_no, seq_done_o, busy_o, rst_cause_o} !== 7'b001_0_1_10) begin
            failures++;
            $display("FAIL arst_pre: rst_no=%b done=%b busy=%b cause=%b, want 001 0 1 10",
                     rst_no, seq_done_o, busy_o, rst_cause_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({rst_no, seq_done_o, busy_o, rst_cause_o} !== 7'b000_0_1_00) begin
            failures++;
            $display("FAIL arst_immediate: rst_no=%b done=%b busy=%b cause=%b, want 000 0 1 00",
                     rst_no, seq_done_o, busy_o, rst_cause_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        base = cyc;
        push_seq(base, 2'b00, "arst_por");
        while (sb.size() > 0) begin
            @(posedge clk_i); #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.cyc != cyc || rst_no !== e.rst || seq_done_o !== e.done ||
                    busy_o !== ~e.done || rst_cause_o !== e.cause) begin
                    failures++;
                    $display("FAIL %s edge=%0d: rst_no=%b done=%b busy=%b cause=%b, want rst_no=%b done=%b cause=%b",
                             e.name, e.cyc, rst_no, seq_done_o, busy_o, rst_cause_o, e.rst, e.done, e.cause);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ext_glitch();
        test_ext_hold();
        test_sw_run();
        test_sw_release();
        test_simultaneous();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
